// File: rtl/gpio_switch_reader.sv
// gpio_switch_reader: synchronises and debounces the GPIO switch/button pads,
// then reports every debounced level change as one event through a small FIFO.
module gpio_switch_reader #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     sw_in,
  output logic [WIDTH-1:0]     sw_level,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [2*WIDTH-1:0]   evt_data,
  output logic                 evt_overflow,
  input  logic                 clear_overflow
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [WIDTH-1:0]   sync_p0;
  logic [WIDTH-1:0]   sync_p1;
  logic [WIDTH-1:0]   stable;
  logic [WIDTH-1:0]   stable_next;
  logic [WIDTH-1:0]   change_mask;
  logic [CNT_W-1:0]   cnt      [WIDTH];
  logic [CNT_W-1:0]   cnt_next [WIDTH];

  logic [2*WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               push;
  logic               pop;
  logic               full;
  logic               push_ok;
  logic               drop;

  // Stage p0 -> p1: two-flop synchroniser for the asynchronous pads.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= sw_in;
      sync_p1 <= sync_p0;
    end
  end

  // Per-bit debounce decision: count disagreeing cycles, flip on the last one.
  always_comb begin
    change_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync_p1[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) change_mask[i] = 1'b1;
        else                   cnt_next[i]    = cnt[i] + CNT_W'(1);
      end
    end
  end

  assign stable_next = stable ^ change_mask;

  // Debounce state: stable levels and their disagreement counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      stable <= stable_next;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push      = |change_mask;
  assign full      = (count == FULL_CNT);
  assign evt_valid = (count != '0);
  assign pop       = evt_valid & evt_ready;
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;

  // Event storage; contents are only meaningful behind the occupancy count.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= {change_mask, stable_next};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                 evt_overflow <= 1'b0;
    else if (drop)           evt_overflow <= 1'b1;
    else if (clear_overflow) evt_overflow <= 1'b0;
  end

  assign sw_level = stable;
  assign evt_data = evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_gpio_switch_reader.sv
// Bench for gpio_switch_reader: directed scenarios plus a randomized run
// scored against a sample-window reference model.
module tb_gpio_switch_reader;

  localparam int W     = 8;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [W-1:0]   sw_in = '0;
  logic           evt_ready = 1'b0;
  logic           clear_overflow = 1'b0;
  logic [W-1:0]   sw_level;
  logic           evt_valid;
  logic [2*W-1:0] evt_data;
  logic           evt_overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  gpio_switch_reader #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .sw_in(sw_in), .sw_level(sw_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_overflow(evt_overflow), .clear_overflow(clear_overflow)
  );

  always #5 CLK = ~CLK;

  // Reference model: a bit takes a new level once its last DEB synchronised
  // samples (raw samples delayed by two edges) all disagree with it.
  logic [W-1:0]   m_hist[$];
  logic [W-1:0]   m_stable;
  logic [2*W-1:0] m_q[$];
  logic           m_ovf;

  always @(posedge CLK or posedge RST) begin : model
    logic [W-1:0] mask;
    logic         dropped;
    if (RST) begin
      m_hist.delete();
      for (int k = 0; k < DEB + 1; k++) m_hist.push_back('0);
      m_stable = '0;
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      mask = '1;
      for (int k = 0; k < DEB; k++) mask = mask & (m_hist[k] ^ m_stable);
      dropped = 1'b0;
      if ((m_q.size() != 0) && evt_ready) void'(m_q.pop_front());
      if (mask != '0) begin
        if (m_q.size() < DEPTH) m_q.push_back({mask, m_stable ^ mask});
        else dropped = 1'b1;
      end
      if (dropped)             m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
      m_stable = m_stable ^ mask;
      m_hist.push_back(sw_in);
      void'(m_hist.pop_front());
    end
  end

  task automatic settle(input logic [W-1:0] v);
    sw_in = v;
    repeat (8) @(negedge CLK);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLK);
    n_cmp++; if (sw_level !== 8'h00) begin n_fail++; $display("FAIL reset_level: got %h want 00", sw_level); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
    n_cmp++; if (evt_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", evt_data); end
    n_cmp++; if (evt_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", evt_overflow); end
    RST = 1'b0;
  endtask

  task automatic test_single_change;
    sw_in = 8'h01;
    repeat (5) @(negedge CLK);
    n_cmp++; if (sw_level !== 8'h00) begin n_fail++; $display("FAIL single_early_level: got %h want 00", sw_level); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", evt_valid); end
    @(negedge CLK);
    n_cmp++; if (sw_level !== 8'h01) begin n_fail++; $display("FAIL single_level: got %h want 01", sw_level); end
    n_cmp++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", evt_valid); end
    n_cmp++; if (evt_data !== 16'h0101) begin n_fail++; $display("FAIL single_data: got %h want 0101", evt_data); end
    evt_ready = 1'b1;
    @(negedge CLK);
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: got %b want 0", evt_valid); end
    evt_ready = 1'b0;
  endtask

  task automatic test_glitch;
    evt_ready = 1'b1;
    settle(8'h00);
    evt_ready = 1'b0;
    n_cmp++; if (sw_level !== 8'h00) begin n_fail++; $display("FAIL glitch_start_level: got %h want 00", sw_level); end
    sw_in = 8'h08;
    repeat (3) @(negedge CLK);
    sw_in = 8'h00;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      n_cmp++; if (sw_level !== 8'h00) begin n_fail++; $display("FAIL glitch_level c%0d: got %h want 00", c, sw_level); end
      n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_event c%0d: got %b want 0", c, evt_valid); end
    end
    sw_in = 8'h08;
    repeat (6) @(negedge CLK);
    sw_in = 8'h00;
    repeat (14) @(negedge CLK);
    n_cmp++; if (evt_data !== 16'h0808) begin n_fail++; $display("FAIL pulse_rise: got %h want 0808", evt_data); end
    evt_ready = 1'b1;
    @(negedge CLK);
    evt_ready = 1'b0;
    n_cmp++; if (evt_data !== 16'h0800) begin n_fail++; $display("FAIL pulse_fall: got %h want 0800", evt_data); end
    evt_ready = 1'b1;
    @(negedge CLK);
    evt_ready = 1'b0;
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL pulse_drained: got %b want 0", evt_valid); end
  endtask

  task automatic test_simultaneous;
    settle(8'hA5);
    n_cmp++; if (evt_data !== 16'hA5A5) begin n_fail++; $display("FAIL simul_data: got %h want A5A5", evt_data); end
    evt_ready = 1'b1;
    @(negedge CLK);
    evt_ready = 1'b0;
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL simul_single: got %b want 0", evt_valid); end
  endtask

  task automatic test_overflow;
    logic [2*W-1:0] exp_q [4];
    exp_q = '{16'h01A4, 16'h01A5, 16'h01A4, 16'h01A5};
    settle(8'hA4); settle(8'hA5); settle(8'hA4); settle(8'hA5);
    n_cmp++; if (evt_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b want 0", evt_overflow); end
    settle(8'hA4);
    n_cmp++; if (evt_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", evt_overflow); end
    sw_in = 8'hA5;
    repeat (5) @(negedge CLK);
    n_cmp++; if (sw_level !== 8'hA4) begin n_fail++; $display("FAIL ovf_pre6_level: got %h want A4", sw_level); end
    clear_overflow = 1'b1;
    @(negedge CLK);
    clear_overflow = 1'b0;
    n_cmp++; if (sw_level !== 8'hA5) begin n_fail++; $display("FAIL ovf_6_level: got %h want A5", sw_level); end
    n_cmp++; if (evt_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", evt_overflow); end
    clear_overflow = 1'b1;
    @(negedge CLK);
    clear_overflow = 1'b0;
    n_cmp++; if (evt_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", evt_overflow); end
    evt_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_cmp++; if (evt_data !== exp_q[j]) begin n_fail++; $display("FAIL ovf_order%0d: got %h want %h", j, evt_data, exp_q[j]); end
      @(negedge CLK);
    end
    evt_ready = 1'b0;
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b want 0", evt_valid); end
  endtask

  task automatic test_full_push_pop;
    logic [2*W-1:0] exp_q [4];
    exp_q = '{16'h80A5, 16'h8025, 16'h80A5, 16'h8025};
    settle(8'h25); settle(8'hA5); settle(8'h25); settle(8'hA5);
    n_cmp++; if (evt_data !== 16'h8025) begin n_fail++; $display("FAIL full_head: got %h want 8025", evt_data); end
    sw_in = 8'h25;
    repeat (5) @(negedge CLK);
    evt_ready = 1'b1;
    @(negedge CLK);
    evt_ready = 1'b0;
    n_cmp++; if (sw_level !== 8'h25) begin n_fail++; $display("FAIL full_level: got %h want 25", sw_level); end
    n_cmp++; if (evt_overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf: got %b want 0", evt_overflow); end
    evt_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_cmp++; if (evt_data !== exp_q[j]) begin n_fail++; $display("FAIL full_order%0d: got %h want %h", j, evt_data, exp_q[j]); end
      @(negedge CLK);
    end
    evt_ready = 1'b0;
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", evt_valid); end
  endtask

  task automatic test_reset_mid;
    settle(8'h24); settle(8'h25);
    n_cmp++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL mid_queued: got %b want 1", evt_valid); end
    sw_in = 8'h00;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    #1;
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", evt_valid); end
    n_cmp++; if (sw_level !== 8'h00) begin n_fail++; $display("FAIL mid_level: got %h want 00", sw_level); end
    n_cmp++; if (evt_overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %b want 0", evt_overflow); end
    sw_in = 8'hFF;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    n_cmp++; if (sw_level !== 8'h00) begin n_fail++; $display("FAIL mid_early: got %h want 00", sw_level); end
    @(negedge CLK);
    n_cmp++; if (sw_level !== 8'hFF) begin n_fail++; $display("FAIL mid_level_ff: got %h want FF", sw_level); end
    n_cmp++; if (evt_data !== 16'hFFFF) begin n_fail++; $display("FAIL mid_event: got %h want FFFF", evt_data); end
    evt_ready = 1'b1;
    @(negedge CLK);
    evt_ready = 1'b0;
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_one_event: got %b want 0", evt_valid); end
  endtask

  task automatic test_random;
    logic [W-1:0]   v;
    logic           exp_v;
    logic [2*W-1:0] exp_d;
    int             hold;
    v = sw_in;
    for (int seg = 0; seg < 250; seg++) begin
      case ($urandom_range(0, 3))
        0:       v = W'($urandom);
        1, 2:    v = v ^ (W'(1) << $urandom_range(0, W - 1));
        default: v = v;
      endcase
      sw_in = v;
      hold = $urandom_range(1, 10);
      for (int c = 0; c < hold; c++) begin
        evt_ready      = ($urandom_range(0, 2) == 0);
        clear_overflow = ($urandom_range(0, 9) == 0);
        RST            = ($urandom_range(0, 199) == 0);
        @(negedge CLK);
        exp_v = (m_q.size() != 0);
        exp_d = exp_v ? m_q[0] : '0;
        n_cmp++; if (sw_level !== m_stable) begin n_fail++; $display("FAIL rand_level seg%0d: got %h want %h", seg, sw_level, m_stable); end
        n_cmp++; if (evt_valid !== exp_v) begin n_fail++; $display("FAIL rand_valid seg%0d: got %b want %b", seg, evt_valid, exp_v); end
        n_cmp++; if (evt_data !== exp_d) begin n_fail++; $display("FAIL rand_data seg%0d: got %h want %h", seg, evt_data, exp_d); end
        n_cmp++; if (evt_overflow !== m_ovf) begin n_fail++; $display("FAIL rand_ovf seg%0d: got %b want %b", seg, evt_overflow, m_ovf); end
      end
    end
    RST = 1'b0;
    evt_ready = 1'b0;
    clear_overflow = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_change;
    test_glitch;
    test_simultaneous;
    test_overflow;
    test_full_push_pop;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
